// File: rtl/rtlinf_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is presented on data_read whenever empty=0.
// Optional FIFO_DEBUG_EN macro adds simulation-only transaction tracing without changing function.
module rtlinf_fifo #(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  localparam logic [LOG_NUM_SLOTS:0]   C_CNT_FULL  = NUM_SLOTS[LOG_NUM_SLOTS:0];
  localparam logic [LOG_NUM_SLOTS:0]   C_CNT_AFULL = C_CNT_FULL - {{LOG_NUM_SLOTS{1'b0}}, 1'b1};
  localparam logic [LOG_NUM_SLOTS:0]   C_CNT_ONE   = {{LOG_NUM_SLOTS{1'b0}}, 1'b1};
  localparam logic [LOG_NUM_SLOTS-1:0] C_PTR_ONE   = {{(LOG_NUM_SLOTS-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]    r_mem [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] r_wr_ptr;
  logic [LOG_NUM_SLOTS-1:0] r_rd_ptr;
  logic [LOG_NUM_SLOTS:0]   r_count;
  logic [LOG_NUM_SLOTS:0]   w_count_nxt;
  logic                     w_rd_acc;
  logic                     w_wr_acc;

  // Flag decode and head-of-queue presentation straight from registered state
  always_comb begin
    empty       = (r_count == {(LOG_NUM_SLOTS+1){1'b0}});
    full        = (r_count == C_CNT_FULL);
    almost_full = (r_count >= C_CNT_AFULL);
    data_read   = r_mem[r_rd_ptr];
  end

  // Acceptance: a pop at full frees the slot the same-cycle push lands in
  always_comb begin
    w_rd_acc = next_read & ~empty;
    w_wr_acc = write & (~full | w_rd_acc);
  end

  // Occupancy update; a simultaneous push and pop leaves the count unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + C_CNT_ONE;
      2'b01:   w_count_nxt = r_count - C_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage, pointers and count; reset discards all contents immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_mem[r_wr_ptr] <= data_write;
        r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_count <= w_count_nxt;
    end
  end

`ifdef FIFO_DEBUG_EN
  logic [31:0] r_dbg_tick;

  // Simulation-only trace of accepted, dropped and ignored transactions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbg_tick <= 32'd0;
    end else begin
      r_dbg_tick <= r_dbg_tick + 32'd1;
      if (w_wr_acc) $display("[fifo %0d] write data=%h count=%0d", r_dbg_tick, data_write, r_count);
      if (w_rd_acc) $display("[fifo %0d] read  data=%h count=%0d", r_dbg_tick, data_read, r_count);
      if (write && !w_wr_acc) $display("[fifo %0d] warning: write dropped (full)", r_dbg_tick);
      if (next_read && !w_rd_acc) $display("[fifo %0d] warning: read ignored (empty)", r_dbg_tick);
    end
  end
`endif

endmodule

// File: tb/tb_rtlinf_fifo.sv
// Randomised self-checking bench for rtlinf_fifo (4 slots x 8 bits) against a queue-based model.
module tb_rtlinf_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_write = 8'h00;
  logic       write = 1'b0;
  logic       next_read = 1'b0;
  logic       full, almost_full, empty;
  logic [7:0] data_read;

  logic [7:0] m_q[$];
  int checks = 0;
  int errors = 0;

  rtlinf_fifo #(.NUM_SLOTS(4), .LOG_NUM_SLOTS(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .data_write(data_write), .write(write),
    .full(full), .almost_full(almost_full), .data_read(data_read),
    .next_read(next_read), .empty(empty)
  );

  always #5 clk = ~clk;

  // One clock: drive, update the reference queue by the FIFO rules, settle 1 ns past the edge
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    bit rd, wr;
    write = w; data_write = d; next_read = r;
    rd = r && (m_q.size() != 0);
    wr = w && ((m_q.size() < 4) || rd);
    @(posedge clk);
    if (rd) void'(m_q.pop_front());
    if (wr) m_q.push_back(d);
    #1;
    write = 1'b0; next_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", almost_full); end
    checks++; if (data_read !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_read); end
    @(posedge clk); #1;
    rst = 1'b1;
    m_q.delete();
  endtask

  task automatic test_fill();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL fill2_afull got %b exp 0", almost_full); end
    step(1'b1, 8'h33, 1'b0);
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill3_afull got %b exp 1", almost_full); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill3_full got %b exp 0", full); end
    step(1'b1, 8'h44, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill4_full got %b exp 1", full); end
    checks++; if (data_read !== 8'h11) begin errors++; $display("FAIL fill_head got %h exp 11", data_read); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    step(1'b1, 8'h55, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_read !== exp_seq[i] || data_read !== m_q[0])
        begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, data_read, exp_seq[i]); end
      step(1'b0, 8'h00, 1'b1);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b exp 1", empty); end
  endtask

  task automatic test_fwft();
    step(1'b1, 8'hA5, 1'b1);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fwft_empty got %b exp 0", empty); end
    checks++; if (data_read !== 8'hA5) begin errors++; $display("FAIL fwft_data got %h exp a5", data_read); end
    step(1'b0, 8'h00, 1'b1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwft_pop got %b exp 1", empty); end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp_seq [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    step(1'b1, 8'h11, 1'b0); step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0); step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h66, 1'b1);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL simul_full got %b exp 1", full); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_read !== exp_seq[i])
        begin errors++; $display("FAIL simul_order[%0d] got %h exp %h", i, data_read, exp_seq[i]); end
      step(1'b0, 8'h00, 1'b1);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b exp 1", empty); end
  endtask

  task automatic test_stream();
    logic [7:0] got[$];
    int budget;
    for (int i = 0; i < 20; i++) begin
      if (!empty) got.push_back(data_read);
      step(1'b1, 8'(i), 1'b1);
    end
    budget = 10;
    while (!empty && budget > 0) begin
      got.push_back(data_read);
      step(1'b0, 8'h00, 1'b1);
      budget--;
    end
    checks++; if (got.size() != 20) begin errors++; $display("FAIL stream_len got %0d exp 20", got.size()); end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      checks++;
      if (got[i] !== 8'(i)) begin errors++; $display("FAIL stream[%0d] got %h exp %h", i, got[i], 8'(i)); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45));
      checks++;
      if (empty !== (m_q.size() == 0) || full !== (m_q.size() == 4) || almost_full !== (m_q.size() >= 3))
        begin errors++; $display("FAIL rand_flags[%0d] got e%b f%b af%b exp count %0d", n, empty, full, almost_full, m_q.size()); end
      if (m_q.size() != 0) begin
        checks++;
        if (data_read !== m_q[0]) begin errors++; $display("FAIL rand_head[%0d] got %h exp %h", n, data_read, m_q[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    while (m_q.size() < 2) step(1'b1, 8'($urandom), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    m_q.delete();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b exp 1", empty); end
    checks++; if (data_read !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", data_read); end
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, 8'h5C, 1'b0);
    checks++; if (data_read !== 8'h5C || empty !== 1'b0) begin errors++; $display("FAIL midrst_after got %h/%b exp 5c/0", data_read, empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_fwft();
    test_full_simul();
    test_stream();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
